// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the
// downstream consumer of the shared mux output.
interface rr_mux_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int SEL_W = 2
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       lock;
   logic [N_REQ*WIDTH-1:0] data_in;
   logic [N_REQ-1:0]       gnt;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic [SEL_W-1:0]       out_src;

   // Sources and consumer side
   modport master (
      output req, lock, data_in, out_ready,
      input  gnt, out_valid, out_data, out_src
   );

   // Arbiter side
   modport slave (
      input  req, lock, data_in, out_ready,
      output gnt, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 word mux into a single registered output
// stage with valid/ready handshake. A requester that raises lock together with
// req keeps the mux for as long as both stay high.
module rr_mux_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int SEL_W = 2
) (
   input logic              clk,
   input logic              rst_n,
   rr_mux_arbiter_if.slave  bus
);

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_owner;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_src;

   logic             w_hold;
   logic [N_REQ-1:0] w_eligible;
   logic [SEL_W-1:0] w_winner;
   logic             w_found;
   logic             w_load;
   logic [SEL_W-1:0] w_next_ptr;
   logic [N_REQ-1:0] w_gnt;

   // The burst continues only while the owner keeps both req and lock high;
   // otherwise this same cycle falls back to normal round-robin.
   assign w_hold = (r_state == ST_LOCKED) && bus.req[r_owner] && bus.lock[r_owner];

   // Restrict the candidate set to the owner while a burst is held
   always_comb begin
      w_eligible = bus.req;
      if (w_hold) begin
         w_eligible          = '0;
         w_eligible[r_owner] = 1'b1;
      end
   end

   // Pick the first eligible requester searching upward from the pointer, wrapping
   always_comb begin
      int idx;
      idx      = 0;
      w_winner = r_ptr;
      w_found  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!w_found && w_eligible[idx[SEL_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = idx[SEL_W-1:0];
         end
      end
   end

   // A word is consumed only when the output stage is free or draining this cycle
   assign w_load     = rst_n && (!r_out_valid || bus.out_ready) && w_found;
   assign w_next_ptr = (w_winner == SEL_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;

   // One-hot grant to the winning source in the cycle its word is captured
   always_comb begin
      w_gnt = '0;
      if (w_load) begin
         w_gnt[w_winner] = 1'b1;
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_src   = r_out_src;

   // Arbitration FSM, pointer and registered output stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_ARB;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.data_in[w_winner*WIDTH +: WIDTH];
         r_out_src   <= w_winner;
         // While holding, the pointer already sits just past the owner
         if (!w_hold) begin
            r_ptr <= w_next_ptr;
         end
         if (bus.lock[w_winner]) begin
            r_state <= ST_LOCKED;
            r_owner <= w_winner;
         end else begin
            r_state <= ST_ARB;
         end
      end else begin
         if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if ((r_state == ST_LOCKED) && !w_hold) begin
            r_state <= ST_ARB;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (N_REQ=4, WIDTH=4). Source i always
// presents word i+1. Expected beats are queued when a grant is predicted and
// compared when the output register loads.
module tb_rr_mux_arbiter;
   localparam int N = 4;
   localparam int W = 4;
   localparam int S = 2;

   typedef struct packed {
      logic [S-1:0] src;
      logic [W-1:0] data;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst_n;
   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.N_REQ(N), .WIDTH(W), .SEL_W(S)) bus ();

   rr_mux_arbiter #(.N_REQ(N), .WIDTH(W), .SEL_W(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gnt cyc %0d: got %b expected 0000", c, bus.gnt);
         end
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_out cyc %0d: got v=%b d=%h s=%0d expected v=0 d=0 s=0",
                     c, bus.out_valid, bus.out_data, bus.out_src);
         end
      end
      $display("reset: outputs cleared");
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_gnt;
      beat_t        e;
      bus.req = 4'b1111; bus.lock = 4'b0000; bus.out_ready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         exp_gnt = 4'b0001 << (b % 4);
         @(negedge clk);
         n_checks++;
         if (bus.gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL rr_gnt beat %0d: got %b expected %b", b, bus.gnt, exp_gnt);
         end
         exp_q.push_back('{src: S'(b % 4), data: W'(b % 4 + 1)});
         @(posedge clk); #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rr_out beat %0d: got s=%0d expected queued beat", b, bus.out_src);
         end else begin
            e = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
               n_fail++;
               $display("FAIL rr_out beat %0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                        b, bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
            end
         end
         $display("round_robin beat %0d: src=%0d data=%h", b, bus.out_src, bus.out_data);
      end
   endtask

   task automatic test_backpressure();
      beat_t e;
      // Load source 1 (word 2), then stall
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_first_gnt: got %b expected 0010", bus.gnt);
      end
      exp_q.push_back('{src: 2'd1, data: 4'h2});
      @(posedge clk); #1;
      n_checks++;
      e = exp_q.pop_front();
      if (bus.out_src !== e.src || bus.out_data !== e.data) begin
         n_fail++;
         $display("FAIL bp_first_out: got s=%0d d=%h expected s=%0d d=%h",
                  bus.out_src, bus.out_data, e.src, e.data);
      end
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_stall_gnt cyc %0d: got %b expected 0000", c, bus.gnt);
         end
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h2 || bus.out_src !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_stall_out cyc %0d: got v=%b d=%h s=%0d expected v=1 d=2 s=1",
                     c, bus.out_valid, bus.out_data, bus.out_src);
         end
         $display("backpressure stall %0d: data=%h held", c, bus.out_data);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL bp_release_gnt: got %b expected 0100", bus.gnt);
      end
      exp_q.push_back('{src: 2'd2, data: 4'h3});
      @(posedge clk); #1;
      n_checks++;
      e = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
         n_fail++;
         $display("FAIL bp_release_out: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                  bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
      end
      $display("backpressure release: src=%0d data=%h", bus.out_src, bus.out_data);
   endtask

   task automatic test_lock();
      logic [N-1:0] exp_gnt;
      beat_t        e;
      bus.req = 4'b0011; bus.lock = 4'b0001; bus.out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         if (b == 3) bus.lock = 4'b0000;
         exp_gnt = (b < 3) ? 4'b0001 : 4'b0010;
         @(negedge clk);
         n_checks++;
         if (bus.gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL lock_gnt beat %0d: got %b expected %b", b, bus.gnt, exp_gnt);
         end
         exp_q.push_back((b < 3) ? '{src: 2'd0, data: 4'h1} : '{src: 2'd1, data: 4'h2});
         @(posedge clk); #1;
         n_checks++;
         e = exp_q.pop_front();
         if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
            n_fail++;
            $display("FAIL lock_out beat %0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     b, bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
         end
         $display("lock beat %0d: src=%0d data=%h", b, bus.out_src, bus.out_data);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL lock_idle_gnt: got %b expected 0000", bus.gnt);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_idle_valid: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [N-1:0] req_tab [3];
      logic [N-1:0] gnt_tab [3];
      beat_t        e;
      // ptr is 2 on entry: 0100 moves it to 3, 0001 wraps to source 0 (ptr->1),
      // and 0011 then proves ptr=1 by picking source 1.
      req_tab = '{4'b0100, 4'b0001, 4'b0011};
      gnt_tab = '{4'b0100, 4'b0001, 4'b0010};
      bus.lock = 4'b0000; bus.out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bus.req = req_tab[b];
         @(negedge clk);
         n_checks++;
         if (bus.gnt !== gnt_tab[b]) begin
            n_fail++;
            $display("FAIL wrap_gnt beat %0d: got %b expected %b", b, bus.gnt, gnt_tab[b]);
         end
         case (gnt_tab[b])
            4'b0001: exp_q.push_back('{src: 2'd0, data: 4'h1});
            4'b0010: exp_q.push_back('{src: 2'd1, data: 4'h2});
            4'b0100: exp_q.push_back('{src: 2'd2, data: 4'h3});
            default: exp_q.push_back('{src: 2'd3, data: 4'h4});
         endcase
         @(posedge clk); #1;
         n_checks++;
         e = exp_q.pop_front();
         if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
            n_fail++;
            $display("FAIL wrap_out beat %0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     b, bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
         end
         $display("wrap beat %0d: req=%b src=%0d data=%h", b, req_tab[b], bus.out_src, bus.out_data);
      end
      bus.req = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_idle_gnt: got %b expected 0000", bus.gnt);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_idle_valid: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      beat_t e;
      bus.req = 4'b0001; bus.lock = 4'b0001; bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("FAIL rmid_lock_gnt: got %b expected 0001", bus.gnt);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1) begin
         n_fail++;
         $display("FAIL rmid_stall: got v=%b d=%h expected v=1 d=1", bus.out_valid, bus.out_data);
      end
      // Ready high too, so only reset keeps gnt low
      rst_n = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL rmid_rst_gnt: got %b expected 0000", bus.gnt);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin
         n_fail++;
         $display("FAIL rmid_rst_out: got v=%b d=%h s=%0d expected v=0 d=0 s=0",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      $display("reset mid-burst: output dropped");
      rst_n = 1'b1; bus.req = 4'b0100; bus.lock = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== 4'b0100) begin
         n_fail++;
         $display("FAIL rmid_after_gnt: got %b expected 0100", bus.gnt);
      end
      exp_q.push_back('{src: 2'd2, data: 4'h3});
      @(posedge clk); #1;
      n_checks++;
      e = exp_q.pop_front();
      if (bus.out_valid !== 1'b1 || bus.out_src !== e.src || bus.out_data !== e.data) begin
         n_fail++;
         $display("FAIL rmid_after_out: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                  bus.out_valid, bus.out_src, bus.out_data, e.src, e.data);
      end
      $display("after reset: src=%0d data=%h", bus.out_src, bus.out_data);
      bus.req = 4'b0000;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req       = 4'b1111;
      bus.lock      = 4'b0000;
      bus.out_ready = 1'b1;
      bus.data_in   = {4'h4, 4'h3, 4'h2, 4'h1};
      test_reset();
      test_round_robin();
      test_backpressure();
      test_lock();
      test_wrap();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
